// File: rtl/jtag_unlock_ctrl.sv
// Debug-port unlock controller: serial key compare, failed-attempt counting and sticky lockout.
// Optional auto-relock timer is compiled in with `define JTAG_UNLOCK_TIMEOUT_EN.
module jtag_unlock_ctrl #(
  parameter int unsigned KEY_W     = 16,
  parameter logic [KEY_W-1:0] KEY  = 16'hA5C3,
  parameter int unsigned MAX_TRIES = 3,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           key_valid,
  input  logic                           key_bit,
  input  logic                           relock,
  output logic                           o_unlock,
  output logic                           o_lockout,
  output logic                           o_pass,
  output logic                           o_fail,
  output logic [$clog2(MAX_TRIES+1)-1:0] o_tries
);

  localparam int unsigned TW  = $clog2(MAX_TRIES + 1);
  localparam int unsigned CW  = $clog2(KEY_W);

  if (KEY_W < 2 || MAX_TRIES < 1 || TIMEOUT < 1) begin : g_bad_param
    $error("jtag_unlock_ctrl: illegal parameter value");
  end

  typedef enum logic [1:0] {StLocked, StCheck, StUnlocked, StLockout} state_e;

  state_e           state;
  logic [CW-1:0]    cnt;
  logic [KEY_W-1:0] sr;
  logic [TW-1:0]    tries_inc;

`ifdef JTAG_UNLOCK_TIMEOUT_EN
  localparam int unsigned TMW = $clog2(TIMEOUT + 1);
  logic [TMW-1:0] timer;
`endif

  always_comb begin
    tries_inc = o_tries + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= StLocked;
      cnt       <= '0;
      sr        <= '0;
      o_tries   <= '0;
      o_unlock  <= 1'b0;
      o_lockout <= 1'b0;
      o_pass    <= 1'b0;
      o_fail    <= 1'b0;
`ifdef JTAG_UNLOCK_TIMEOUT_EN
      timer     <= '0;
`endif
    end else begin
      o_pass <= 1'b0;
      o_fail <= 1'b0;
      case (state)
        StLocked: begin
          // relock aborts a partial key and discards any bit offered in the same cycle
          if (relock) begin
            cnt <= '0;
          end else if (key_valid) begin
            sr <= {sr[KEY_W-2:0], key_bit};
            if (cnt == CW'(KEY_W - 1)) begin
              cnt   <= '0;
              state <= StCheck;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        StCheck: begin
          if (sr == KEY) begin
            state    <= StUnlocked;
            o_pass   <= 1'b1;
            o_unlock <= 1'b1;
            o_tries  <= '0;
`ifdef JTAG_UNLOCK_TIMEOUT_EN
            timer    <= TMW'(TIMEOUT);
`endif
          end else begin
            o_fail <= 1'b1;
            if (o_tries != TW'(MAX_TRIES)) begin
              o_tries <= tries_inc;
            end
            if (tries_inc == TW'(MAX_TRIES)) begin
              state     <= StLockout;
              o_lockout <= 1'b1;
            end else begin
              state <= StLocked;
            end
          end
        end
        StUnlocked: begin
          if (relock) begin
            state    <= StLocked;
            o_unlock <= 1'b0;
          end
`ifdef JTAG_UNLOCK_TIMEOUT_EN
          else if (timer == TMW'(1)) begin
            state    <= StLocked;
            o_unlock <= 1'b0;
            timer    <= '0;
          end else begin
            timer <= timer - TMW'(1);
          end
`endif
        end
        StLockout: begin
          o_unlock  <= 1'b0;
          o_lockout <= 1'b1;
        end
        default: begin
          state <= StLocked;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_unlock_ctrl.sv
// Directed self-checking bench for jtag_unlock_ctrl.
// Covers reset, pass/fail, lockout, aborts and relock/timeout behaviour.
module tb_jtag_unlock_ctrl;

`ifdef JTAG_UNLOCK_TIMEOUT_EN
  localparam int unsigned TmoCycles = 4;
`else
  localparam int unsigned TmoCycles = 255;
`endif

  logic       clk = 1'b0;
  logic       reset, key_valid, key_bit, relock;
  logic       o_unlock, o_lockout, o_pass, o_fail;
  logic [1:0] o_tries;

  int checks = 0;
  int errors = 0;
  int fail_seen = 0;

  jtag_unlock_ctrl #(
    .KEY_W    (16),
    .KEY      (16'hA5C3),
    .MAX_TRIES(3),
    .TIMEOUT  (TmoCycles)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .key_valid(key_valid),
    .key_bit  (key_bit),
    .relock   (relock),
    .o_unlock (o_unlock),
    .o_lockout(o_lockout),
    .o_pass   (o_pass),
    .o_fail   (o_fail),
    .o_tries  (o_tries)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_fail === 1'b1) fail_seen++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_bits(input logic [15:0] k, input int n, input bit gap);
    for (int i = 0; i < n; i++) begin
      key_valid = 1'b1;
      key_bit   = k[15-i];
      step();
      if (gap && i < n - 1) begin
        key_valid = 1'b0;
        key_bit   = 1'b1;
        step();
      end
    end
    key_valid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_unlock"},  {31'd0, o_unlock},  32'd0);
    check({tag, "_lockout"}, {31'd0, o_lockout}, 32'd0);
    check({tag, "_pass"},    {31'd0, o_pass},    32'd0);
    check({tag, "_fail"},    {31'd0, o_fail},    32'd0);
    check({tag, "_tries"},   {30'd0, o_tries},   32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int f0;
    int hi;
    reset = 1'b1; key_valid = 1'b1; key_bit = 1'b0; relock = 1'b0;

    // Reset with key bits being offered
    for (int i = 0; i < 2; i++) begin
      key_bit = 1'($urandom_range(0, 1));
      step();
      check_all_zero("rst_during");
    end
    reset = 1'b0; key_valid = 1'b0;
    step();
    check_all_zero("rst_after");

    // Correct key, back-to-back bits; a bit offered during CHECK must be dropped
    shift_bits(16'hA5C3, 16, 1'b0);
    check("chk_state_unlock", {31'd0, o_unlock}, 32'd0);
    check("chk_state_pass",   {31'd0, o_pass},   32'd0);
    key_valid = 1'b1; key_bit = 1'b1;
    step();
    key_valid = 1'b0;
    check("pass_pulse",  {31'd0, o_pass},   32'd1);
    check("pass_unlock", {31'd0, o_unlock}, 32'd1);
    check("pass_tries",  {30'd0, o_tries},  32'd0);
    check("pass_nofail", {31'd0, o_fail},   32'd0);
    relock = 1'b1;
    step();
    relock = 1'b0;
    check("relock_unlock", {31'd0, o_unlock}, 32'd0);
    check("pass_one_cyc",  {31'd0, o_pass},   32'd0);

    // Two wrong keys, then the right one
    shift_bits(16'h0000, 16, 1'b0);
    step();
    check("fail1_pulse", {31'd0, o_fail},  32'd1);
    check("fail1_tries", {30'd0, o_tries}, 32'd1);
    step();
    check("fail1_one_cyc", {31'd0, o_fail}, 32'd0);
    shift_bits(16'h0000, 16, 1'b0);
    step();
    check("fail2_pulse",   {31'd0, o_fail},    32'd1);
    check("fail2_tries",   {30'd0, o_tries},   32'd2);
    check("fail2_lockout", {31'd0, o_lockout}, 32'd0);
    shift_bits(16'hA5C3, 16, 1'b0);
    step();
    check("retry_unlock", {31'd0, o_unlock}, 32'd1);
    check("retry_tries",  {30'd0, o_tries},  32'd0);
    relock = 1'b1;
    step();
    relock = 1'b0;

    // Three wrong keys reach lockout; a correct key is then ignored
    for (int n = 0; n < 3; n++) begin
      shift_bits(16'hFFFF, 16, 1'b0);
      step();
    end
    check("lock_tries",   {30'd0, o_tries},   32'd3);
    check("lock_flag",    {31'd0, o_lockout}, 32'd1);
    check("lock_unlock0", {31'd0, o_unlock},  32'd0);
    shift_bits(16'hA5C3, 16, 1'b0);
    step();
    step();
    check("lock_key_ignored", {31'd0, o_unlock},  32'd0);
    check("lock_no_pass",     {31'd0, o_pass},    32'd0);
    check("lock_sticky",      {31'd0, o_lockout}, 32'd1);
    check("lock_tries_sat",   {30'd0, o_tries},   32'd3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("lock_rst_flag",  {31'd0, o_lockout}, 32'd0);
    check("lock_rst_tries", {30'd0, o_tries},   32'd0);

    // Abort by relock after 8 bits; relock wins over a concurrent key bit
    f0 = fail_seen;
    shift_bits(16'hFF00, 8, 1'b0);
    relock = 1'b1; key_valid = 1'b1; key_bit = 1'b1;
    step();
    relock = 1'b0; key_valid = 1'b0;
    shift_bits(16'hA5C3, 16, 1'b0);
    step();
    check("abort_relock_unlock", {31'd0, o_unlock}, 32'd1);
    check("abort_relock_nofail", fail_seen - f0, 32'd0);
    relock = 1'b1;
    step();
    relock = 1'b0;

    // Abort by reset after 10 bits; full key then sent with gaps between bits
    shift_bits(16'h1234, 10, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    shift_bits(16'hA5C3, 16, 1'b1);
    step();
    check("abort_rst_unlock", {31'd0, o_unlock}, 32'd1);
    check("abort_rst_pass",   {31'd0, o_pass},   32'd1);

`ifdef JTAG_UNLOCK_TIMEOUT_EN
    // Count cycles o_unlock stays high, starting with the cycle after CHECK
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      if (o_unlock) hi++;
      step();
    end
    check("tmo_high_cycles", hi, 32'd4);
    check("tmo_unlock_low",  {31'd0, o_unlock}, 32'd0);
    check("tmo_tries_kept",  {30'd0, o_tries},  32'd0);
`else
    hi = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (o_unlock) hi++;
    end
    check("no_tmo_hold_cycles", hi, 32'd1000);
    check("no_tmo_unlock",      {31'd0, o_unlock}, 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jtag_unlock_ctrl.md
# jtag_unlock_ctrl

- Debug-port unlock controller; produces the lock-enable signal that gates writes to protected debug registers.
- Accepts a serially shifted key and compares it against a compile-time password.
- Asserts `o_unlock` only after a correct key; holds it deasserted from reset.
- Counts failed attempts and enters a sticky lockout after too many failures.

## Interface
- `KEY_W`, 16, key length in bits (≥2)
- `KEY`, 16'hA5C3, expected key value, `KEY_W` bits
- `MAX_TRIES`, 3, failed attempts before lockout (≥1)
- `TIMEOUT`, 255, cycles the port stays unlocked when auto-relock is compiled in (≥1)

Ports:
- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `key_valid`  in  1  qualifies `key_bit` this cycle
- `key_bit`  in  1  key bit, MSB first
- `relock`  in  1  request to return to locked state / abort partial key
- `o_unlock`  out  1  1 = protected writes permitted
- `o_lockout`  out  1  sticky lockout flag
- `o_pass`  out  1  one-cycle pulse: key matched
- `o_fail`  out  1  one-cycle pulse: key mismatched
- `o_tries`  out  $clog2(MAX_TRIES+1)  failed-attempt count

## Operation
- Reset values:
  - state LOCKED
  - all outputs 0
  - bit counter, shift register, tries and timer all 0
- Reset dominates every other input in any state, including mid-shift.
- **LOCKED**
  - Each `key_valid` cycle shifts `key_bit` into the shift register LSB, so the first bit ends in the MSB, and increments the bit counter.
  - The edge that samples bit `KEY_W-1` moves the state to CHECK and clears the bit counter.
  - `relock` clears the bit counter. It takes priority over `key_valid` in the same cycle; that bit is discarded.
- **CHECK** (exactly one cycle)
  - Inputs are ignored.
  - Match: go to UNLOCKED, pulse `o_pass`, clear tries.
  - Mismatch: tries+1 and pulse `o_fail`. If the new tries equals `MAX_TRIES`, go to LOCKOUT; otherwise go to LOCKED.
- **UNLOCKED**
  - `o_unlock`=1.
  - `key_valid` is ignored.
  - `relock` returns to LOCKED on the next edge.
- **LOCKOUT**
  - `o_lockout`=1, `o_unlock`=0.
  - All inputs ignored; exited only by `reset`.
- All outputs are registered; none is combinational from inputs.
- `o_tries` saturates at `MAX_TRIES`.
- Comparison covers all `KEY_W` bits; there is no partial match.

## Timing
- Last key bit sampled at edge k → state is CHECK after edge k.
- After edge k+1: `o_unlock` and `o_pass` high on a match, or `o_fail` high on a mismatch (`o_lockout` too if tries reaches the limit).
- `o_pass` / `o_fail` are high for exactly one cycle.
- `relock` sampled at edge j in UNLOCKED → `o_unlock` low after edge j.
- A new key may start the cycle after a return to LOCKED. Bits presented during CHECK are dropped.
- Back-to-back `key_valid` every cycle is supported; gaps between bits are allowed and preserve progress.

## Configuration
- `JTAG_UNLOCK_TIMEOUT_EN` defined:
  - A timer loads `TIMEOUT` on entry to UNLOCKED and decrements each cycle in UNLOCKED.
  - The edge where the timer is 1 returns the state to LOCKED, so `o_unlock` is high for exactly `TIMEOUT` cycles.
  - `relock` in the same cycle gives the same result.
  - Timeout does not change tries.
- Undefined:
  - No timer logic is present.
  - UNLOCKED persists until `relock` or `reset`.

## Test plan
- **Reset:** assert `reset` for 2 cycles with `key_valid`=1 and random `key_bit` → every output 0 during and after, state LOCKED.
- **Correct key:** shift 16'hA5C3 on 16 consecutive cycles → `o_pass` pulse and `o_unlock`=1 two edges after the last bit, `o_tries`=0. Then `relock` → `o_unlock`=0 after one edge.
- **Retry then pass:** shift 16'h0000 twice → two `o_fail` pulses, `o_tries`=2, `o_lockout`=0. Then shift 16'hA5C3 → unlock, `o_tries`=0.
- **Lockout:** shift 16'hFFFF three times → `o_tries`=3 and `o_lockout`=1 after the third CHECK. Then shift 16'hA5C3 → `o_unlock` stays 0. `reset` → `o_lockout`=0, `o_tries`=0.
- **Aborts:**
  - Shift 8 bits, pulse `relock`, then shift 16'hA5C3 → unlock, with no `o_fail`.
  - Shift 10 bits, assert `reset`, then shift the full key → unlock.
- **Timeout** (macro defined, `TIMEOUT`=4): correct key → `o_unlock` high for exactly 4 cycles, then 0. Without the macro → `o_unlock` still 1 after 1000 cycles.
